pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: BOOT/RUN/PEND state machine with trap > jump > branch redirects.
// Optional macro PC_ALIGN_CHECK_EN rejects misaligned targets instead of masking them.
module pc_sequencer #(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] RST_PC = XLEN'(RESET_VECTOR);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_nxt_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_nxt_pc;
    logic [XLEN-1:0] r_pending;
    logic [XLEN-1:0] w_nxt_pending;
    logic            r_valid;
    logic            w_sel;
    logic            w_bad;
    logic [XLEN-1:0] w_tgt_raw;
    logic [XLEN-1:0] w_tgt;
    logic            w_take_trap;
    logic            w_take_redir;
    logic            w_advance;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

    // Select the highest-priority request and its raw target; BOOT only honours traps.
    always_comb begin
        w_tgt_raw = branch_target_i;
        w_sel     = 1'b0;
        if (trap_i) begin
            w_tgt_raw = trap_vector_i;
            w_sel     = 1'b1;
        end else if ((r_state != ST_BOOT) && jump_i) begin
            w_tgt_raw = jump_target_i;
            w_sel     = 1'b1;
        end else if ((r_state != ST_BOOT) && branch_i) begin
            w_tgt_raw = branch_target_i;
            w_sel     = 1'b1;
        end else begin
            w_sel     = 1'b0;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign w_bad = w_sel & (w_tgt_raw[1:0] != 2'b00);
    assign w_tgt = w_tgt_raw;
`else
    assign w_bad = 1'b0;
    assign w_tgt = word_align(w_tgt_raw);
`endif

    // A rejected target behaves exactly like no request at all.
    assign w_take_trap  = trap_i & w_sel & ~w_bad;
    assign w_take_redir = ~trap_i & w_sel & ~w_bad;
    assign w_advance    = r_valid & fetch_ready_i & ~stall_i;

    // Next-state, next-PC and pending-target selection.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_pc      = r_pc;
        w_nxt_pending = r_pending;
        case (r_state)
            ST_BOOT: begin
                w_nxt_state = ST_RUN;
                if (w_take_trap) begin
                    w_nxt_pc      = w_tgt;
                    w_nxt_pending = '0;
                end else begin
                    w_nxt_pc      = r_pc;
                end
            end
            ST_RUN, ST_PEND: begin
                if (w_take_trap) begin
                    w_nxt_pc      = w_tgt;
                    w_nxt_pending = '0;
                    w_nxt_state   = ST_RUN;
                end else if (w_advance) begin
                    if (w_take_redir) begin
                        w_nxt_pc = w_tgt;
                    end else if (r_state == ST_PEND) begin
                        w_nxt_pc = r_pending;
                    end else begin
                        w_nxt_pc = r_pc + XLEN'(4);
                    end
                    w_nxt_pending = '0;
                    w_nxt_state   = ST_RUN;
                end else if (w_take_redir) begin
                    w_nxt_pending = w_tgt;
                    w_nxt_state   = ST_PEND;
                end else begin
                    w_nxt_state   = r_state;
                end
            end
            default: begin
                w_nxt_state   = ST_BOOT;
                w_nxt_pc      = RST_PC;
                w_nxt_pending = '0;
            end
        endcase
    end

    // State, PC, pending target and valid flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_BOOT;
            r_pc      <= RST_PC;
            r_pending <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_pc      <= w_nxt_pc;
            r_pending <= w_nxt_pending;
            r_valid   <= (w_nxt_state != ST_BOOT);
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;

    // One-cycle pulse for each rejected target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_bad;
        end
    end

    assign misalign_o = r_misalign;
`else
    assign misalign_o = 1'b0;
`endif

    assign pc_o       = r_pc;
    assign pc_valid_o = r_valid;
    assign pc_plus4_o = r_pc + XLEN'(4);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset corner sequences, and
// randomized traffic checked against a rule-level reference model.
module tb_pc_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_ready_i = 1'b0;
    logic            stall_i = 1'b0;
    logic            branch_i = 1'b0;
    logic [XLEN-1:0] branch_target_i = '0;
    logic            jump_i = 1'b0;
    logic [XLEN-1:0] jump_target_i = '0;
    logic            trap_i = 1'b0;
    logic [XLEN-1:0] trap_vector_i = '0;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            misalign_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_ready_i(fetch_ready_i), .stall_i(stall_i),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .trap_i(trap_i), .trap_vector_i(trap_vector_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o),
        .pc_plus4_o(pc_plus4_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fr, st, br, jp, tr;
        logic [31:0] bt, jt, tv;
        logic [31:0] epc;
        logic        ev, em;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fr, input logic st, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt, input logic tr, input logic [31:0] tv);
        fetch_ready_i = fr; stall_i = st;
        branch_i = br; branch_target_i = bt;
        jump_i = jp; jump_target_i = jt;
        trap_i = tr; trap_vector_i = tv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] epc, input logic ev, input logic em);
        chk({tag, ".pc"}, pc_o, epc);
        chk({tag, ".valid"}, {31'd0, pc_valid_o}, {31'd0, ev});
        chk({tag, ".plus4"}, pc_plus4_o, epc + 32'd4);
        chk({tag, ".mis"}, {31'd0, misalign_o}, {31'd0, em});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_outs("rst", 32'h100, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outs("rst_rel", 32'h100, 1'b0, 1'b0);
    endtask

    // Reference model: spec rules over PC, a pending slot and a "booted" flag.
    logic        m_booted, m_has_pend, m_mis;
    logic [31:0] m_pc, m_pend;

    task automatic model_reset();
        m_booted = 1'b0; m_has_pend = 1'b0; m_mis = 1'b0;
        m_pc = 32'h100; m_pend = 32'd0;
    endtask

    task automatic model_step(input logic fr, input logic st, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt, input logic tr, input logic [31:0] tv);
        logic        req, is_trap, adv;
        logic [31:0] t;
        is_trap = tr;
        req = tr || (m_booted && (jp || br));
        t = tr ? tv : (jp ? jt : bt);
        m_mis = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        if (req && (t % 4 != 0)) begin
            req = 1'b0;
            m_mis = 1'b1;
        end
`else
        t = t - (t % 4);
`endif
        adv = m_booted && fr && !st;
        if (req && is_trap) begin
            m_pc = t; m_has_pend = 1'b0;
        end else if (!m_booted) begin
            m_pc = m_pc;
        end else if (adv) begin
            m_pc = req ? t : (m_has_pend ? m_pend : m_pc + 32'd4);
            m_has_pend = 1'b0;
        end else if (req) begin
            m_has_pend = 1'b1; m_pend = t;
        end
        m_booted = 1'b1;
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic fr, input logic st, input logic br, input logic [31:0] bt,
                                input logic jp, input logic [31:0] jt, input logic tr, input logic [31:0] tv,
                                input logic [31:0] epc, input logic em);
        vec_t v;
        v.fr = fr; v.st = st; v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
        v.tr = tr; v.tv = tv; v.epc = epc; v.ev = 1'b1; v.em = em;
        return v;
    endfunction

    initial begin
        // Directed table starting from reset with RESET_VECTOR=0x100.
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h100, 0)); // BOOT->RUN only
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h104, 0));
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h108, 0));
        vecs.push_back(mk(0,0,0,0,          0,0,          1,32'h200, 32'h200, 0)); // trap w/o ready
        vecs.push_back(mk(0,0,1,32'h300,    0,0,          0,0,     32'h200, 0)); // to PEND
        vecs.push_back(mk(0,0,0,0,          1,32'h400,    0,0,     32'h200, 0)); // newest wins
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h400, 0));
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h404, 0));
        vecs.push_back(mk(1,1,0,0,          0,0,          0,0,     32'h404, 0)); // stall holds
        vecs.push_back(mk(1,0,0,0,          1,32'h500,    0,0,     32'h500, 0));
        vecs.push_back(mk(1,1,1,32'h600,    0,0,          0,0,     32'h500, 0)); // PEND via stall
        vecs.push_back(mk(1,1,0,0,          0,0,          1,32'h80, 32'h080, 0)); // trap under stall
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h084, 0)); // pending cleared
        vecs.push_back(mk(1,0,1,32'h10,     1,32'h20,     0,0,     32'h020, 0)); // jump > branch
        vecs.push_back(mk(0,0,1,32'h700,    0,0,          0,0,     32'h020, 0));
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h700, 0)); // PEND release
        vecs.push_back(mk(1,0,0,0,          1,32'hFFFF_FFFC, 0,0,  32'hFFFF_FFFC, 0));
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h0,   0)); // wrap
`ifdef PC_ALIGN_CHECK_EN
        vecs.push_back(mk(1,0,0,0,          1,32'h102,    0,0,     32'h4,   1));
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h8,   0));
`else
        vecs.push_back(mk(1,0,0,0,          1,32'h102,    0,0,     32'h100, 0));
        vecs.push_back(mk(1,0,0,0,          0,0,          0,0,     32'h104, 0));
`endif

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].fr, vecs[i].st, vecs[i].br, vecs[i].bt,
                  vecs[i].jp, vecs[i].jt, vecs[i].tr, vecs[i].tv);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ev, vecs[i].em);
        end

        // Reset mid-PEND discards pending; BOOT ignores branch but not trap.
        drive(0,0,1,32'h900, 0,0, 0,0);
        tick();
        do_reset();
        drive(1,0,1,32'h900, 1,32'hA00, 0,0);
        tick();
        check_outs("boot_ign", 32'h100, 1'b1, 1'b0);
        drive(1,0,0,0, 0,0, 0,0);
        tick();
        check_outs("no_stale", 32'h104, 1'b1, 1'b0);
        do_reset();
        drive(0,0,0,0, 0,0, 1,32'hC0);
        tick();
        check_outs("boot_trap", 32'hC0, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 400; n++) begin
            logic fr, st, br, jp, tr;
            logic [31:0] bt, jt, tv;
            fr = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 4) == 0);
            br = ($urandom_range(0, 3) == 0);
            jp = ($urandom_range(0, 4) == 0);
            tr = ($urandom_range(0, 11) == 0);
            bt = $urandom; jt = $urandom; tv = $urandom;
            if ($urandom_range(0, 7) != 0) bt = bt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) != 0) jt = jt & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) != 0) tv = tv & 32'hFFFF_FFFC;
            drive(fr, st, br, bt, jp, jt, tr, tv);
            model_step(fr, st, br, bt, jp, jt, tr, tv);
            tick();
            check_outs($sformatf("rnd%0d", n), m_pc, m_booted, m_mis);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
